// File: rtl/motion_pkg.sv
// Shared types and constants for the frame motion detector:
// motion FSM state encoding, default frame resolution, counter width helper.
package motion_pkg;

   // Default frame geometry (QVGA)
   localparam int DEF_H_RES = 320;
   localparam int DEF_V_RES = 240;

   // Filtered motion state
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_MOTION = 1'b1
   } motion_state_t;

   // Bits needed to hold any count from 0 up to and including num_pixels
   function automatic int cnt_width(input int num_pixels);
      return $clog2(num_pixels + 1);
   endfunction

endpackage

// File: rtl/frame_motion_detector_if.sv
// Pixel/frame bus of the frame motion detector.
// master = pixel source and result consumer, slave = the detector.
interface frame_motion_detector_if
   import motion_pkg::*;
#(
   parameter int PIX_W      = 4,
   parameter int NUM_FRAMES = 3,
   parameter int CNT_W      = cnt_width(DEF_H_RES * DEF_V_RES)
);

   logic                             pixel_valid;
   logic                             frame_done;
   logic [NUM_FRAMES-1:0][PIX_W-1:0] sobel_pix;       // [0] = oldest frame
   logic [CNT_W-1:0]                 motion_th;
   logic [PIX_W-1:0]                 diff_pixel;
   logic                             diff_pixel_valid;
   logic [CNT_W-1:0]                 diff_pixel_cnt;
   logic [CNT_W-1:0]                 frame_diff_cnt;
   logic                             cnt_valid;
   logic                             motion_detected;

   modport master (
      output pixel_valid, frame_done, sobel_pix, motion_th,
      input  diff_pixel, diff_pixel_valid, diff_pixel_cnt,
             frame_diff_cnt, cnt_valid, motion_detected
   );

   modport slave (
      input  pixel_valid, frame_done, sobel_pix, motion_th,
      output diff_pixel, diff_pixel_valid, diff_pixel_cnt,
             frame_diff_cnt, cnt_valid, motion_detected
   );

endinterface

// File: rtl/pixel_abs_diff.sv
// Compares one pixel between two adjacent frame taps: flags the pair as
// changed when the unsigned absolute difference reaches DIFF_TH.
module pixel_abs_diff #(
   parameter int PIX_W   = 4,
   parameter int DIFF_TH = 2
) (
   input  logic [PIX_W-1:0] older,
   input  logic [PIX_W-1:0] newer,
   output logic             changed
);

   // Difference is formed one bit wider than the pixel so no magnitude is lost
   localparam logic [PIX_W:0] TH = (PIX_W + 1)'(DIFF_TH);

   logic [PIX_W:0] older_ext;
   logic [PIX_W:0] newer_ext;
   logic [PIX_W:0] abs_diff;

   // Absolute difference and threshold compare
   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here
      // unconditionally) so no latch is inferred.
      older_ext = {1'b0, older};
      newer_ext = {1'b0, newer};
      abs_diff  = (newer_ext >= older_ext) ? (newer_ext - older_ext)
                                           : (older_ext - newer_ext);
      changed   = (abs_diff >= TH);
   end

endmodule

// File: rtl/frame_motion_detector.sv
// Frame motion detector: marks pixels that changed across every adjacent
// pair of frame taps, counts them per frame, latches the count at
// frame_done and derives a motion flag from it.
// Build option: define MOTION_HYST_EN to filter the motion flag through an
// IDLE/MOTION hysteresis FSM; otherwise the flag follows the last frame.
module frame_motion_detector
   import motion_pkg::*;
#(
   parameter int PIX_W       = 4,
   parameter int NUM_FRAMES  = 3,
   parameter int H_RES       = DEF_H_RES,
   parameter int V_RES       = DEF_V_RES,
   parameter int DIFF_TH     = 2,
   parameter int HYST_FRAMES = 3
) (
   input  logic                    clk_25MHz,
   input  logic                    reset,      // synchronous, active low
   frame_motion_detector_if.slave  bus
);

   localparam int               PIXELS  = H_RES * V_RES;
   localparam int               CNT_W   = cnt_width(PIXELS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIXELS);

   logic [NUM_FRAMES-2:0] pair_changed;
   logic                  pix_changed;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  frame_active;

   logic [PIX_W-1:0]      diff_pixel_r;
   logic                  diff_pixel_valid_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      frame_diff_cnt_r;
   logic                  cnt_valid_r;
   logic                  motion_r;

   // One comparator per adjacent pair of frame taps
   for (genvar k = 0; k < NUM_FRAMES - 1; k++) begin : g_pair
      pixel_abs_diff #(
         .PIX_W   (PIX_W),
         .DIFF_TH (DIFF_TH)
      ) u_pair (
         .older   (bus.sobel_pix[k]),
         .newer   (bus.sobel_pix[k+1]),
         .changed (pair_changed[k])
      );
   end

   // A pixel counts only if every pair moved and the taps are valid
   assign pix_changed = bus.pixel_valid & (&pair_changed);

   // Saturating next count, and the activity decision for the frame that
   // closes this cycle (includes a changed pixel arriving with frame_done)
   always_comb begin
      cnt_inc = cnt_r;
      if (pix_changed && (cnt_r != CNT_MAX)) begin
         cnt_inc = cnt_r + 1'b1;
      end
      frame_active = (cnt_inc > bus.motion_th);
   end

   // Registered per-pixel difference output, one cycle behind the taps
   always_ff @(posedge clk_25MHz) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the values from before the edge.
      if (!reset) begin
         diff_pixel_r       <= '0;
         diff_pixel_valid_r <= 1'b0;
      end else begin
         diff_pixel_valid_r <= bus.pixel_valid;
         diff_pixel_r       <= pix_changed ? '1 : '0;
      end
   end

   // Live changed-pixel count, latched and cleared at every frame_done;
   // a frame_done on the cycle after another closes an empty frame
   always_ff @(posedge clk_25MHz) begin
      if (!reset) begin
         cnt_r            <= '0;
         frame_diff_cnt_r <= '0;
         cnt_valid_r      <= 1'b0;
      end else begin
         cnt_valid_r <= bus.frame_done;
         if (bus.frame_done) begin
            frame_diff_cnt_r <= cnt_inc;
            cnt_r            <= '0;
         end else begin
            cnt_r <= cnt_inc;
         end
      end
   end

`ifdef MOTION_HYST_EN
   localparam int               RUN_W    = $clog2(HYST_FRAMES + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HYST_FRAMES - 1);

   motion_state_t    state_r;
   logic [RUN_W-1:0] run_r;

   // Hysteresis FSM: switch state after HYST_FRAMES consecutive frames
   // that disagree with it; any agreeing frame restarts the run
   always_ff @(posedge clk_25MHz) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         run_r    <= '0;
         motion_r <= 1'b0;
      end else if (bus.frame_done) begin
         unique case (state_r)
            ST_IDLE: begin
               if (!frame_active) begin
                  run_r <= '0;
               end else if (run_r == RUN_LAST) begin
                  state_r  <= ST_MOTION;
                  run_r    <= '0;
                  motion_r <= 1'b1;
               end else begin
                  run_r <= run_r + 1'b1;
               end
            end
            ST_MOTION: begin
               if (frame_active) begin
                  run_r <= '0;
               end else if (run_r == RUN_LAST) begin
                  state_r  <= ST_IDLE;
                  run_r    <= '0;
                  motion_r <= 1'b0;
               end else begin
                  run_r <= run_r + 1'b1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               run_r    <= '0;
               motion_r <= 1'b0;
            end
         endcase
      end
   end
`else
   // Unfiltered flag: activity of the most recently latched frame
   always_ff @(posedge clk_25MHz) begin
      if (!reset) begin
         motion_r <= 1'b0;
      end else if (bus.frame_done) begin
         motion_r <= frame_active;
      end
   end
`endif

   assign bus.diff_pixel       = diff_pixel_r;
   assign bus.diff_pixel_valid = diff_pixel_valid_r;
   assign bus.diff_pixel_cnt   = cnt_r;
   assign bus.frame_diff_cnt   = frame_diff_cnt_r;
   assign bus.cnt_valid        = cnt_valid_r;
   assign bus.motion_detected  = motion_r;

endmodule

// File: doc/frame_motion_detector.md
FRAME_MOTION_DETECTOR -- requirements
Module: frame_motion_detector

Interface
REQ-001 SHALL have parameter PIX_W, default 4, meaning Sobel pixel width.
REQ-002 SHALL have parameter NUM_FRAMES, default 3, range 2..8, meaning number of frame taps compared (NUM_FRAMES-1 adjacent pairs).
REQ-003 SHALL have parameter H_RES, default 320, and V_RES, default 240, meaning frame size.
REQ-004 SHALL have parameter DIFF_TH, default 2, meaning minimum absolute pixel difference counted as changed.
REQ-005 SHALL have parameter HYST_FRAMES, default 3, meaning consecutive frames required to change motion state.
REQ-006 SHALL have port clk_25MHz, input, 1, system clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 SHALL have port pixel_valid, input, 1, pixel taps valid this cycle.
REQ-009 SHALL have port frame_done, input, 1, single-cycle end-of-frame pulse.
REQ-010 SHALL have port sobel_pix, input, NUM_FRAMES x PIX_W, index 0 = oldest frame.
REQ-011 SHALL have port motion_th, input, CNT_W, runtime changed-pixel threshold.
REQ-012 SHALL have port diff_pixel, output, PIX_W, all-ones if changed, else zero.
REQ-013 SHALL have port diff_pixel_valid, output, 1, qualifies diff_pixel.
REQ-014 SHALL have port diff_pixel_cnt, output, CNT_W, live count of the current frame.
REQ-015 SHALL have port frame_diff_cnt, output, CNT_W, count latched at the last frame_done.
REQ-016 SHALL have port cnt_valid, output, 1, one-cycle pulse when frame_diff_cnt updates.
REQ-017 SHALL have port motion_detected, output, 1, filtered motion flag.

Function
REQ-018 SHALL define pair k as changed when |sobel_pix[k+1] - sobel_pix[k]| >= DIFF_TH, computed unsigned in PIX_W+1 bits.
REQ-019 SHALL flag a pixel as changed only when all NUM_FRAMES-1 pairs are changed and pixel_valid=1.
REQ-020 SHALL register diff_pixel and diff_pixel_valid with exactly 1-cycle latency from pixel_valid.
REQ-021 SHALL hold diff_pixel at zero while diff_pixel_valid=0.
REQ-022 SHALL increment diff_pixel_cnt by one per changed pixel and saturate at H_RES*V_RES.
REQ-023 SHALL define CNT_W as $clog2(H_RES*V_RES+1).
REQ-024 SHALL, on frame_done, copy the count (including any changed pixel in the same cycle) to frame_diff_cnt, clear diff_pixel_cnt to zero next cycle, and pulse cnt_valid for one cycle.
REQ-025 SHALL classify a frame as active when the latched count > motion_th, sampled with motion_th at frame_done.
REQ-026 SHALL use a two-state FSM, IDLE and MOTION; IDLE->MOTION after HYST_FRAMES consecutive active frames; MOTION->IDLE after HYST_FRAMES consecutive inactive frames; a run counter restarts on any frame that agrees with the current state.
REQ-027 SHALL update motion_detected in the same cycle as cnt_valid.
REQ-028 SHALL ignore a frame_done asserted on consecutive cycles beyond the first; the second pulse latches a zero-count frame.

Reset
REQ-029 SHALL, while reset=0 at a clk_25MHz edge, clear diff_pixel, diff_pixel_valid, diff_pixel_cnt, frame_diff_cnt, cnt_valid, motion_detected, and the run counter, and put the FSM in IDLE.
REQ-030 SHALL discard any partial-frame count on reset mid-frame; counting resumes from zero at the first valid pixel after release.

Configuration
REQ-031 SHALL support macro MOTION_HYST_EN: when defined, REQ-026 hysteresis applies; when undefined, motion_detected equals the active classification of the last latched frame, with no FSM or run counter.

Structure
REQ-032 SHALL place the FSM state typedef, default resolution constants, and the CNT_W function in package motion_pkg.
REQ-033 SHALL implement the per-pair compare of REQ-018 as sub-module pixel_abs_diff, instantiated NUM_FRAMES-1 times.

Verification
REQ-034 SHALL cover: NUM_FRAMES=3, taps 0/5/10, DIFF_TH=2, 10 valid pixels -> 10 diff_pixel=4'hF outputs, each one cycle later; cnt=10 at frame_done.
REQ-035 SHALL cover: taps 5/6/10, DIFF_TH=2 -> pair0 unchanged; diff_pixel=0; count stays 0.
REQ-036 SHALL cover: frame_done coincident with a changed pixel after count 99 -> frame_diff_cnt=100, cnt_valid pulses once, diff_pixel_cnt=0 next cycle.
REQ-037 SHALL cover: 76800 changed pixels plus extra changed pixels -> count saturates at 76800.
REQ-038 SHALL cover: with MOTION_HYST_EN defined and motion_th=50, frame counts 60,60,60 -> motion_detected=1 at the third cnt_valid; then 10,60,10,10,10 -> motion_detected=0 at the fifth.
REQ-039 SHALL cover: reset=0 mid-frame at count 37 -> all outputs zero; next frame counts from 0.
